// File: rtl/fifo_mult_pkg.sv
// Shared types and helpers for the FIFO-fed sequential multiplier.
package fifo_mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int DEFAULT_W = 8;
   localparam int ENTRY_W   = 2 * DEFAULT_W + 1;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // FIFO entry is {mode, A, B}.
   function automatic int entry_width(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/mult_sync_fifo.sv
// Synchronous show-ahead FIFO with a registered free-slot count and a
// sticky overflow flag. A push while full is dropped even if a pop occurs
// in the same cycle.
module mult_sync_fifo
   import fifo_mult_pkg::*;
#(
   parameter int W_DATA = 17,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_req,
   input  logic [W_DATA-1:0]            wr_data,
   input  logic                         pop_req,
   output logic [W_DATA-1:0]            rd_data,
   output logic                         empty,
   output logic [clog2(DEPTH+1)-1:0]    left,
   output logic                         overflow
);

   localparam int PTR_W  = clog2(DEPTH);
   localparam int LEFT_W = clog2(DEPTH + 1);

   logic [W_DATA-1:0] mem_q [DEPTH];
   logic [W_DATA-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LEFT_W-1:0] left_q, left_d;
   logic              ovf_q, ovf_d;
   logic              full;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (left_q == '0);
   assign empty    = (left_q == LEFT_W'(DEPTH));
   assign push_ok  = push_req && !full;
   assign pop_ok   = pop_req && !empty;
   assign rd_data  = mem_q[rd_ptr_q];
   assign left     = left_q;
   assign overflow = ovf_q;

   // Next-state for storage, pointers, slot count and overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q | (push_req && full);
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      left_d = left_q - LEFT_W'(push_ok) + LEFT_W'(pop_ok);
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         left_q   <= LEFT_W'(DEPTH);
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         left_q   <= left_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fifo_mult_engine.sv
// FIFO-fed shift-add multiplier with per-entry signed/unsigned mode and a
// valid/ready result port.
//
//   state  | meaning
//   IDLE   | waiting; pops the FIFO head when one is present
//   CALC   | W shift-add steps on operand magnitudes
//   SIGN   | negates the magnitude product for mixed-sign signed entries
//   DONE   | Product_Valid high, result held until Product_Ready
module fifo_mult_engine
   import fifo_mult_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        Write_Req,
   input  logic [2*W-1:0]              FIFO_Write_Data,
   input  logic                        Signed_Mode,
   output logic [clog2(DEPTH+1)-1:0]   Left_Sig,
   output logic                        Overflow_Sig,
   output logic                        Busy_Sig,
   output logic                        Product_Valid,
   input  logic                        Product_Ready,
   output logic [2*W-1:0]              Product
);

   localparam int EW    = entry_width(W);
   localparam int CNT_W = clog2(W + 1);

   logic [EW-1:0]    head;
   logic             fifo_empty;
   logic             pop;
   logic             head_mode;
   logic [W-1:0]     head_a;
   logic [W-1:0]     head_b;
   logic [W-1:0]     mag_a;
   logic [W-1:0]     mag_b;

   state_t           state_q, state_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;

   mult_sync_fifo #(
      .W_DATA (EW),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push_req (Write_Req),
      .wr_data  ({Signed_Mode, FIFO_Write_Data}),
      .pop_req  (pop),
      .rd_data  (head),
      .empty    (fifo_empty),
      .left     (Left_Sig),
      .overflow (Overflow_Sig)
   );

   assign head_mode = head[EW-1];
   assign head_a    = head[2*W-1:W];
   assign head_b    = head[W-1:0];
   // -2^(W-1) negates to 2^(W-1), which still fits as a W-bit magnitude.
   assign mag_a     = (head_mode && head_a[W-1]) ? -head_a : head_a;
   assign mag_b     = (head_mode && head_b[W-1]) ? -head_b : head_b;

   assign Busy_Sig      = (state_q != S_IDLE);
   assign Product_Valid = (state_q == S_DONE);
   assign Product       = acc_q;

   // Next-state and datapath update for the multiply sequence.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               acc_d    = '0;
               mcand_d  = {{W{1'b0}}, mag_a};
               mplier_d = mag_b;
               cnt_d    = CNT_W'(W);
               neg_d    = head_mode & (head_a[W-1] ^ head_b[W-1]);
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_SIGN;
         end
         S_SIGN: begin
            if (neg_q) acc_d = -acc_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (Product_Ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Engine registers; reset discards any in-flight operation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
      end
   end

endmodule

// File: tb/tb_fifo_mult_engine.sv
// Directed bench for fifo_mult_engine: W=8/DEPTH=4 main instance plus a
// W=4/DEPTH=2 instance for the small configuration.
module tb_fifo_mult_engine;

   logic        CLK;
   logic        RST;

   logic        Write_Req;
   logic [15:0] FIFO_Write_Data;
   logic        Signed_Mode;
   logic [2:0]  Left_Sig;
   logic        Overflow_Sig;
   logic        Busy_Sig;
   logic        Product_Valid;
   logic        Product_Ready;
   logic [15:0] Product;

   logic        wr2;
   logic [7:0]  data2;
   logic        sm2;
   logic [1:0]  left2;
   logic        ovf2;
   logic        busy2;
   logic        val2;
   logic        rdy2;
   logic [7:0]  prod2;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  exp2_q[$];

   fifo_mult_engine #(.W(8), .DEPTH(4)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .Write_Req       (Write_Req),
      .FIFO_Write_Data (FIFO_Write_Data),
      .Signed_Mode     (Signed_Mode),
      .Left_Sig        (Left_Sig),
      .Overflow_Sig    (Overflow_Sig),
      .Busy_Sig        (Busy_Sig),
      .Product_Valid   (Product_Valid),
      .Product_Ready   (Product_Ready),
      .Product         (Product)
   );

   fifo_mult_engine #(.W(4), .DEPTH(2)) dut2 (
      .CLK             (CLK),
      .RST             (RST),
      .Write_Req       (wr2),
      .FIFO_Write_Data (data2),
      .Signed_Mode     (sm2),
      .Left_Sig        (left2),
      .Overflow_Sig    (ovf2),
      .Busy_Sig        (busy2),
      .Product_Valid   (val2),
      .Product_Ready   (rdy2),
      .Product         (prod2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [7:0] a, input logic [7:0] b, input logic m);
      Write_Req       = 1'b1;
      FIFO_Write_Data = {a, b};
      Signed_Mode     = m;
      tick();
      Write_Req       = 1'b0;
   endtask

   task automatic push2(input logic [3:0] a, input logic [3:0] b, input logic m);
      wr2   = 1'b1;
      data2 = {a, b};
      sm2   = m;
      tick();
      wr2   = 1'b0;
   endtask

   task automatic collect1(input string tag, input int budget);
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < budget) begin
         tick();
         cyc++;
         if (Product_Valid && Product_Ready) check(tag, 32'(Product), 32'(exp_q.pop_front()));
      end
      check({tag, "_left_over"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic collect2(input string tag, input int budget);
      int cyc;
      cyc = 0;
      while (exp2_q.size() > 0 && cyc < budget) begin
         tick();
         cyc++;
         if (val2 && rdy2) check(tag, 32'(prod2), 32'(exp2_q.pop_front()));
      end
      check({tag, "_left_over"}, exp2_q.size(), 0);
      exp2_q.delete();
   endtask

   initial begin
      int n;
      int nv;

      RST             = 1'b1;
      Write_Req       = 1'b0;
      FIFO_Write_Data = '0;
      Signed_Mode     = 1'b0;
      Product_Ready   = 1'b0;
      wr2             = 1'b0;
      data2           = '0;
      sm2             = 1'b0;
      rdy2            = 1'b0;
      tick();
      tick();
      check("rst_left",  32'(Left_Sig), 4);
      check("rst_ovf",   32'(Overflow_Sig), 0);
      check("rst_busy",  32'(Busy_Sig), 0);
      check("rst_valid", 32'(Product_Valid), 0);
      check("rst_prod",  32'(Product), 0);
      check("rst_left2", 32'(left2), 2);
      RST = 1'b0;
      tick();

      // 1: single unsigned push, latency from pop to valid
      Product_Ready = 1'b1;
      push1(8'd12, 8'd9, 1'b0);
      check("t1_left_after_push", 32'(Left_Sig), 3);
      check("t1_idle_at_pop", 32'(Busy_Sig), 0);
      tick();
      check("t1_busy_after_pop", 32'(Busy_Sig), 1);
      check("t1_left_after_pop", 32'(Left_Sig), 4);
      n = 0;
      while (!Product_Valid && n < 30) begin
         tick();
         n++;
      end
      check("t1_latency", n, 9);
      check("t1_prod", 32'(Product), 32'h006C);
      tick();
      check("t1_valid_drop", 32'(Product_Valid), 0);
      check("t1_idle", 32'(Busy_Sig), 0);

      // 2 + 4: engine parked in DONE, burst fills FIFO, overflow, release
      Product_Ready = 1'b0;
      push1(8'd2, 8'd3, 1'b0);
      n = 0;
      while (!Product_Valid && n < 30) begin
         tick();
         n++;
      end
      check("t2_prior_valid", 32'(Product_Valid), 1);
      check("t2_prior_prod", 32'(Product), 32'h0006);
      push1(8'd12, 8'd9, 1'b0);
      check("t2_left_a", 32'(Left_Sig), 3);
      push1(8'd33, 8'd10, 1'b0);
      check("t2_left_b", 32'(Left_Sig), 2);
      push1(8'd40, 8'd5, 1'b0);
      check("t2_left_c", 32'(Left_Sig), 1);
      push1(8'd127, 8'd127, 1'b0);
      check("t2_left_d", 32'(Left_Sig), 0);
      check("t2_ovf_before", 32'(Overflow_Sig), 0);
      push1(8'd37, 8'd21, 1'b0);
      check("t2_left_full", 32'(Left_Sig), 0);
      check("t2_ovf_set", 32'(Overflow_Sig), 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t4_hold_valid", 32'(Product_Valid), 1);
         check("t4_hold_prod", 32'(Product), 32'h0006);
         check("t4_hold_left", 32'(Left_Sig), 0);
      end
      Product_Ready = 1'b1;
      exp_q = '{16'h006C, 16'h014A, 16'h00C8, 16'h3F01};
      collect1("t2_result", 80);
      nv = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (Product_Valid) nv++;
      end
      check("t2_dropped_not_run", nv, 0);
      check("t2_left_empty", 32'(Left_Sig), 4);
      check("t2_ovf_sticky", 32'(Overflow_Sig), 1);

      // 3: signed entries, then the same bits as unsigned
      push1(8'hFD, 8'h07, 1'b1);
      check("t3_left_a", 32'(Left_Sig), 3);
      push1(8'h80, 8'h80, 1'b1);
      check("t3_left_push_pop", 32'(Left_Sig), 3);
      push1(8'h7F, 8'hFF, 1'b1);
      push1(8'hFF, 8'hFF, 1'b1);
      push1(8'hFD, 8'h07, 1'b0);
      check("t3_left_full", 32'(Left_Sig), 0);
      exp_q = '{16'hFFEB, 16'h4000, 16'hFF81, 16'h0001, 16'h06EB};
      collect1("t3_result", 100);

      // 5: reset mid-calculation with a second entry queued
      tick();
      push1(8'd100, 8'd3, 1'b0);
      push1(8'd5, 8'd5, 1'b0);
      tick();
      tick();
      tick();
      check("t5_busy_pre", 32'(Busy_Sig), 1);
      check("t5_left_pre", 32'(Left_Sig), 3);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("t5_valid", 32'(Product_Valid), 0);
      check("t5_busy", 32'(Busy_Sig), 0);
      check("t5_left", 32'(Left_Sig), 4);
      check("t5_ovf", 32'(Overflow_Sig), 0);
      check("t5_prod", 32'(Product), 0);
      push1(8'd9, 8'd8, 1'b0);
      exp_q = '{16'h0048};
      collect1("t5_result", 30);
      nv = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (Product_Valid) nv++;
      end
      check("t5_no_stale", nv, 0);

      // 6: W=4, DEPTH=2 instance
      push2(4'hF, 4'hF, 1'b0);
      check("t6_left_a", 32'(left2), 1);
      tick();
      check("t6_left_popped", 32'(left2), 2);
      check("t6_busy", 32'(busy2), 1);
      push2(4'h8, 4'h7, 1'b1);
      push2(4'h1, 4'h1, 1'b0);
      check("t6_left_full", 32'(left2), 0);
      check("t6_ovf_before", 32'(ovf2), 0);
      push2(4'h2, 4'h2, 1'b0);
      check("t6_ovf_set", 32'(ovf2), 1);
      n = 0;
      while (!val2 && n < 20) begin
         tick();
         n++;
      end
      check("t6_first_valid", 32'(val2), 1);
      check("t6_unsigned", 32'(prod2), 32'hE1);
      rdy2 = 1'b1;
      exp2_q = '{8'hC8, 8'h01};
      collect2("t6_result", 40);
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (val2) nv++;
      end
      check("t6_dropped_not_run", nv, 0);
      check("t6_left_empty", 32'(left2), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
